dot_matrix_scanner: RTL

DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

---
 rtl/dot_matrix_pkg.sv | 29 ++
 rtl/dot_frame_buffer.sv | 90 +++++++++
 rtl/dot_matrix_scanner.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dot_matrix_pkg.sv
// -----------------------------------------------------------------------------
// dot_matrix_pkg
// Shared definitions for the dot-matrix column scanner and its frame buffer:
// default geometry, PWM counter width, bank-select encoding and the scan
// phase encoding used by the top-level FSM.
// -----------------------------------------------------------------------------
package dot_matrix_pkg;

    localparam int DEF_COLS = 5;
    localparam int DEF_ROWS = 7;
    localparam int PWM_W    = 4;

    // Which physical bank is currently displayed (front).
    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_e;

    // First cycle of every column slot is a blanking cycle; the rest drive.
    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

    function automatic bank_sel_e other_bank(input bank_sel_e b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/dot_frame_buffer.sv
// -----------------------------------------------------------------------------
// dot_frame_buffer
// Two COLS x ROWS pattern banks. One bank is displayed (front) and read by the
// scanner; the other (back) receives writes. A swap request is remembered
// until the scanner signals the end of a frame, at which point the banks
// exchange roles and swap_ack pulses for one cycle.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   wr_en        : write strobe into the back bank
//   wr_addr      : column to write; values >= COLS are ignored
//   wr_data      : row pattern for wr_addr
//   swap_req     : sets the swap-pending flag
//   frame_end    : enabled cycle that ends the last column slot
//   rd_col       : column read from the front bank
//   rd_data      : front-bank pattern for rd_col (combinational)
//   swap_ack     : registered one-cycle pulse when the swap takes effect
// -----------------------------------------------------------------------------
module dot_frame_buffer
    import dot_matrix_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    localparam int AW  = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    input  logic            swap_req,
    input  logic            frame_end,
    input  logic [AW-1:0]   rd_col,
    output logic [ROWS-1:0] rd_data,
    output logic            swap_ack
);

    localparam logic [AW:0] COLS_L = COLS[AW:0];

    logic [ROWS-1:0] bank_a_q [COLS];
    logic [ROWS-1:0] bank_b_q [COLS];
    bank_sel_e       sel_q, sel_d;
    logic            pending_q, pending_d;
    logic            swap_ack_q;
    logic            wr_ok;
    logic            swap_fire;

    assign wr_ok     = wr_en && ({1'b0, wr_addr} < COLS_L);
    assign swap_fire = frame_end && pending_q;

    // A request arriving on the swap cycle itself arms the following frame,
    // because the clear from the swap and the new set are merged here.
    always_comb begin
        sel_d     = swap_fire ? other_bank(sel_q) : sel_q;
        pending_d = swap_req | (pending_q & ~swap_fire);
    end

    // Writes target the back bank as selected before any swap on this edge,
    // so a write coinciding with a swap ends up in the new front bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) begin
                bank_a_q[c] <= '0;
                bank_b_q[c] <= '0;
            end
        end else if (wr_ok) begin
            if (sel_q == BANK_A) begin
                bank_b_q[wr_addr] <= wr_data;
            end else begin
                bank_a_q[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= BANK_A;
            pending_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            pending_q  <= pending_d;
            swap_ack_q <= swap_fire;
        end
    end

    assign rd_data  = (sel_q == BANK_A) ? bank_a_q[rd_col] : bank_b_q[rd_col];
    assign swap_ack = swap_ack_q;

endmodule

// File: rtl/dot_matrix_scanner.sv
// -----------------------------------------------------------------------------
// dot_matrix_scanner
// Column-multiplexed LED dot-matrix driver. Steps through COLS columns, each
// for dwell+1 enabled cycles; the first cycle of each slot is blanked to
// avoid ghosting between columns. Row data of the active column is gated by
// a free-running 4-bit PWM counter against the bright setting. Pattern data
// lives in a double-buffered frame store with frame-synchronous swapping.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : advance qualifier; low freezes scan and holds outputs
//   wr_en/wr_addr/wr_data : write a column pattern into the back bank
//   swap_req     : request bank swap at the next frame boundary
//   dwell        : slot length minus one, sampled at each slot start
//   bright       : row duty in sixteenths
//   swap_ack     : one-cycle pulse when a swap takes effect
//   frame_start  : one-cycle pulse when the column-0 slot begins
//   col_out      : registered one-hot column select, column 0 on MSB
//   row_out      : registered row data of the active column
// -----------------------------------------------------------------------------
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int COLS           = DEF_COLS,
    parameter int ROWS           = DEF_ROWS,
    parameter int DWELL_W        = 16,
    parameter int COL_ACTIVE_LOW = 0,
    localparam int CW            = $clog2(COLS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [CW-1:0]      wr_addr,
    input  logic [ROWS-1:0]    wr_data,
    input  logic               swap_req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PWM_W-1:0]   bright,
    output logic               swap_ack,
    output logic               frame_start,
    output logic [COLS-1:0]    col_out,
    output logic [ROWS-1:0]    row_out
);

    localparam logic [CW-1:0]   LAST_COL = CW'(COLS - 1);
    localparam logic [COLS-1:0] COL_IDLE = (COL_ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_e        state_q;
    logic [CW-1:0]      col_q;
    logic [CW-1:0]      col_d;
    logic [DWELL_W-1:0] rem_q;
    logic [PWM_W-1:0]   pwm_q;
    logic [COLS-1:0]    col_out_q;
    logic [ROWS-1:0]    row_out_q;
    logic               frame_start_q;
    logic               slot_end;
    logic               frame_end;
    logic [ROWS-1:0]    front_row;

    // Column 0 maps to the most significant bit of col_out.
    function automatic logic [COLS-1:0] col_select(input logic [CW-1:0] idx);
        logic [COLS-1:0] oh;
        oh = '0;
        oh[COLS - 1 - int'(idx)] = 1'b1;
        return (COL_ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    // In the blanking cycle the live dwell input decides the slot length;
    // afterwards the sampled remaining count does.
    always_comb begin
        slot_end = 1'b0;
        if (state_q == SCAN_BLANK) begin
            slot_end = (dwell == '0);
        end else begin
            slot_end = (rem_q == '0);
        end
    end

    assign col_d     = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
    assign frame_end = enable && slot_end && (col_q == LAST_COL);

    dot_frame_buffer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_fb (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .frame_end (frame_end),
        .rd_col    (col_q),
        .rd_data   (front_row),
        .swap_ack  (swap_ack)
    );

    // Scan FSM with registered outputs. Outputs reflect the column index
    // held during the enabled cycle, so they trail it by one enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SCAN_BLANK;
            col_q         <= '0;
            rem_q         <= '0;
            pwm_q         <= '0;
            col_out_q     <= COL_IDLE;
            row_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (enable) begin
                pwm_q <= pwm_q + PWM_W'(1);
                case (state_q)
                    SCAN_BLANK: begin
                        col_out_q     <= COL_IDLE;
                        row_out_q     <= '0;
                        frame_start_q <= (col_q == '0);
                        if (slot_end) begin
                            col_q <= col_d;
                        end else begin
                            state_q <= SCAN_DRIVE;
                            rem_q   <= dwell - DWELL_W'(1);
                        end
                    end
                    SCAN_DRIVE: begin
                        col_out_q <= col_select(col_q);
                        row_out_q <= (pwm_q < bright) ? front_row : '0;
                        if (slot_end) begin
                            state_q <= SCAN_BLANK;
                            col_q   <= col_d;
                        end else begin
                            rem_q <= rem_q - DWELL_W'(1);
                        end
                    end
                    default: state_q <= SCAN_BLANK;
                endcase
            end
        end
    end

    assign col_out     = col_out_q;
    assign row_out     = row_out_q;
    assign frame_start = frame_start_q;

endmodule
